// File: rtl/tb_stream_checker.sv
// Streaming expectation checker: queues expected words, compares each accepted
// actual word against the queue head under a selectable relation, and reports
// pass/fail counts, the first failure and a stall watchdog.
module tb_stream_checker #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [2:0]                 cfg_mode,
  input  logic                       cfg_signed,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [WIDTH-1:0]           act_data,
  output logic [$clog2(DEPTH):0]     exp_level,
  output logic                       pass_pulse,
  output logic                       fail_pulse,
  output logic [31:0]                pass_count,
  output logic [31:0]                fail_count,
  output logic                       fail_seen,
  output logic [31:0]                first_fail_idx,
  output logic [WIDTH-1:0]           first_fail_act,
  output logic [WIDTH-1:0]           first_fail_exp,
  output logic                       timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StTimeout} wd_state_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             init_q;
  logic             pass_pulse_q, fail_pulse_q, fail_seen_q;
  logic [31:0]      pass_count_q, fail_count_q, idx_q, first_idx_q;
  logic [WIDTH-1:0] first_act_q, first_exp_q;
  wd_state_e        state_q, state_d;
  logic [31:0]      stall_q, stall_d;

  logic             full, empty, push, pop, pass;
  logic [WIDTH-1:0] head;
  logic             is_eq, is_lt;

  assign full      = (level_q == FullLevel);
  assign empty     = (level_q == '0);
  // init_q holds exp_ready low until the first edge after reset release
  assign exp_ready = init_q && !full && !clear;
  assign act_ready = !empty && !clear;
  assign push      = exp_valid && exp_ready;
  assign pop       = act_valid && act_ready;
  assign head      = mem[rd_ptr_q];

  // Relation of act_data against the FIFO head
  always_comb begin
    is_eq = (act_data == head);
    is_lt = cfg_signed ? ($signed(act_data) < $signed(head)) : (act_data < head);
    case (cfg_mode)
      3'd0:    pass = is_eq;
      3'd1:    pass = !is_eq;
      3'd2:    pass = is_lt || is_eq;
      3'd3:    pass = is_lt;
      3'd4:    pass = !is_lt;
      3'd5:    pass = !is_lt && !is_eq;
      default: pass = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since level_q gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= exp_data;
  end

  // FIFO pointers, result pulses, counters and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      idx_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_idx_q  <= '0;
      first_act_q  <= '0;
      first_exp_q  <= '0;
    end else if (clear) begin
      init_q       <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      idx_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_idx_q  <= '0;
      first_act_q  <= '0;
      first_exp_q  <= '0;
    end else begin
      init_q       <= 1'b1;
      pass_pulse_q <= pop && pass;
      fail_pulse_q <= pop && !pass;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (pop) begin
        idx_q <= idx_q + 32'd1;
        if (pass) begin
          if (pass_count_q != '1) pass_count_q <= pass_count_q + 32'd1;
        end else begin
          if (fail_count_q != '1) fail_count_q <= fail_count_q + 32'd1;
          if (!fail_seen_q) begin
            fail_seen_q <= 1'b1;
            first_idx_q <= idx_q;
            first_act_q <= act_data;
            first_exp_q <= head;
          end
        end
      end
    end
  end

  // Watchdog state and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Watchdog next state: count cycles the head waits without a handshake
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    if (clear) begin
      state_d = StIdle;
      stall_d = '0;
    end else begin
      case (state_q)
        StIdle, StWait: begin
          if (empty) begin
            state_d = StIdle;
            stall_d = '0;
          end else if (pop) begin
            state_d = StWait;
            stall_d = '0;
          end else begin
            state_d = StWait;
            if (stall_q != '1) stall_d = stall_q + 32'd1;
            if (TIMEOUT_CYCLES != 0 && stall_d == 32'(TIMEOUT_CYCLES)) state_d = StTimeout;
          end
        end
        StTimeout: begin
          state_d = StTimeout;
          stall_d = '0;
        end
        default: begin
          state_d = StIdle;
          stall_d = '0;
        end
      endcase
    end
  end

  assign exp_level      = level_q;
  assign pass_pulse     = pass_pulse_q;
  assign fail_pulse     = fail_pulse_q;
  assign pass_count     = pass_count_q;
  assign fail_count     = fail_count_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = first_idx_q;
  assign first_fail_act = first_act_q;
  assign first_fail_exp = first_exp_q;
  assign timeout        = (state_q == StTimeout);

endmodule

// File: tb/tb_tb_stream_checker.sv
// Directed bench for tb_stream_checker (WIDTH=32, DEPTH=4, TIMEOUT_CYCLES=10).
module tb_tb_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [2:0]  cfg_mode;
  logic        cfg_signed;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_data;
  logic        act_valid;
  logic        act_ready;
  logic [31:0] act_data;
  logic [2:0]  exp_level;
  logic        pass_pulse;
  logic        fail_pulse;
  logic [31:0] pass_count;
  logic [31:0] fail_count;
  logic        fail_seen;
  logic [31:0] first_fail_idx;
  logic [31:0] first_fail_act;
  logic [31:0] first_fail_exp;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  tb_stream_checker #(
    .WIDTH(32),
    .DEPTH(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .cfg_mode(cfg_mode),
    .cfg_signed(cfg_signed),
    .exp_valid(exp_valid),
    .exp_ready(exp_ready),
    .exp_data(exp_data),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_data(act_data),
    .exp_level(exp_level),
    .pass_pulse(pass_pulse),
    .fail_pulse(fail_pulse),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .fail_seen(fail_seen),
    .first_fail_idx(first_fail_idx),
    .first_fail_act(first_fail_act),
    .first_fail_exp(first_fail_exp),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Push one expected word, then offer one actual word and check the result pulse
  task automatic cmp_one(input string tag, input logic [31:0] e, input logic [31:0] a,
                         input logic [2:0] mode, input logic sgn, input logic exp_pass);
    exp_valid = 1'b1;
    exp_data  = e;
    step();
    exp_valid  = 1'b0;
    act_valid  = 1'b1;
    act_data   = a;
    cfg_mode   = mode;
    cfg_signed = sgn;
    step();
    act_valid = 1'b0;
    chk({tag, "_pass"}, pass_pulse, exp_pass);
    chk({tag, "_fail"}, fail_pulse, !exp_pass);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_mode = 3'd0; cfg_signed = 1'b0;
    exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;

    // Reset state
    #1;
    chk("rst_exp_ready", exp_ready, 0);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_level", exp_level, 0);
    chk("rst_pulses", {pass_pulse, fail_pulse}, 0);
    chk("rst_counts", {pass_count, fail_count}, 0);
    chk("rst_fail_seen", fail_seen, 0);
    chk("rst_timeout", timeout, 0);
    #11;
    rst_n = 1'b1;
    #1;
    chk("rel_exp_ready_low", exp_ready, 0);
    step();
    chk("rel_exp_ready_high", exp_ready, 1);

    // EQ stream 1,2,3 back to back
    exp_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_data = 32'(i);
      step();
    end
    exp_valid = 1'b0;
    chk("t1_level3", exp_level, 3);
    act_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      act_data = 32'(i);
      step();
      chk("t1_pulse", pass_pulse, 1);
      chk("t1_count", pass_count, 32'(i));
    end
    act_valid = 1'b0;
    step();
    chk("t1_pulse_end", pass_pulse, 0);
    chk("t1_fail_count", fail_count, 0);
    chk("t1_fail_seen", fail_seen, 0);
    chk("t1_act_ready_empty", act_ready, 0);
    do_clear();

    // EQ with failures: expected 5,6,7 actual 5,9,8
    cmp_one("t2_a", 32'd5, 32'd5, 3'd0, 1'b0, 1'b1);
    cmp_one("t2_b", 32'd6, 32'd9, 3'd0, 1'b0, 1'b0);
    cmp_one("t2_c", 32'd7, 32'd8, 3'd0, 1'b0, 1'b0);
    chk("t2_fail_count", fail_count, 2);
    chk("t2_pass_count", pass_count, 1);
    chk("t2_fail_seen", fail_seen, 1);
    chk("t2_first_idx", first_fail_idx, 1);
    chk("t2_first_act", first_fail_act, 9);
    chk("t2_first_exp", first_fail_exp, 6);
    do_clear();
    chk("t2_cleared", {fail_seen, fail_count, first_fail_idx}, 0);

    // Relations, signed and unsigned, and a reserved mode
    cmp_one("t3_lt_u", 32'h0, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b0);
    cmp_one("t3_lt_s", 32'h0, 32'hFFFF_FFFF, 3'd3, 1'b1, 1'b1);
    cmp_one("t3_le", 32'd10, 32'd10, 3'd2, 1'b0, 1'b1);
    cmp_one("t3_ge", 32'd10, 32'd3, 3'd4, 1'b0, 1'b0);
    cmp_one("t3_ne", 32'd5, 32'd5, 3'd1, 1'b0, 1'b0);
    cmp_one("t3_gt_s", 32'hFFFF_FFFE, 32'd1, 3'd5, 1'b1, 1'b1);
    cmp_one("t3_gt_u", 32'hFFFF_FFFE, 32'd1, 3'd5, 1'b0, 1'b0);
    cmp_one("t3_rsvd", 32'd7, 32'd7, 3'd6, 1'b0, 1'b0);
    cmp_one("t3_ge_s", 32'd4, 32'd4, 3'd4, 1'b1, 1'b1);
    chk("t3_pass_count", pass_count, 4);
    chk("t3_fail_count", fail_count, 5);
    chk("t3_first_idx", first_fail_idx, 0);
    chk("t3_first_act", first_fail_act, 32'hFFFF_FFFF);
    chk("t3_first_exp", first_fail_exp, 0);
    do_clear();

    // Full FIFO: push refused even when a pop happens in the same cycle
    cfg_mode = 3'd0; cfg_signed = 1'b0;
    exp_valid = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      exp_data = 32'(i);
      step();
    end
    chk("t4_level_full", exp_level, 4);
    chk("t4_exp_ready_full", exp_ready, 0);
    exp_data  = 32'd15;
    act_valid = 1'b1;
    act_data  = 32'd11;
    step();
    exp_valid = 1'b0;
    chk("t4_level_after_pop", exp_level, 3);
    chk("t4_pulse", pass_pulse, 1);
    for (int i = 12; i <= 14; i++) begin
      act_data = 32'(i);
      step();
    end
    chk("t4_level_empty", exp_level, 0);
    chk("t4_act_ready_empty", act_ready, 0);
    step();
    act_valid = 1'b0;
    chk("t4_no_pulse_empty", pass_pulse, 0);
    chk("t4_pass_count", pass_count, 4);
    do_clear();

    // Watchdog: timeout exactly 10 cycles after the word is queued
    exp_valid = 1'b1;
    exp_data  = 32'd42;
    step();
    exp_valid = 1'b0;
    repeat (9) step();
    chk("t5_timeout_early", timeout, 0);
    step();
    chk("t5_timeout_set", timeout, 1);
    act_valid = 1'b1;
    act_data  = 32'd42;
    step();
    act_valid = 1'b0;
    chk("t5_late_pass", pass_pulse, 1);
    chk("t5_late_count", pass_count, 1);
    step();
    chk("t5_timeout_sticky", timeout, 1);
    do_clear();
    chk("t5_timeout_cleared", timeout, 0);

    // Clear mid-stream with a result in flight
    exp_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_data = 32'(i);
      step();
    end
    exp_valid = 1'b0;
    act_valid = 1'b1;
    act_data  = 32'd1;
    step();
    act_valid = 1'b0;
    clear     = 1'b1;
    #1;
    chk("t6_inflight_pulse", pass_pulse, 1);
    chk("t6_readies_blocked", {exp_ready, act_ready}, 0);
    step();
    clear = 1'b0;
    chk("t6_counts", {pass_count, fail_count}, 0);
    chk("t6_level", exp_level, 0);
    chk("t6_timeout", timeout, 0);

    // Asynchronous reset mid-stream discards the in-flight handshake
    exp_valid = 1'b1;
    exp_data  = 32'd8;
    step();
    step();
    exp_valid = 1'b0;
    act_valid = 1'b1;
    act_data  = 32'd8;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_level_async", exp_level, 0);
    chk("t7_readies_async", {exp_ready, act_ready}, 0);
    chk("t7_counts_async", {pass_count, fail_count}, 0);
    step();
    chk("t7_no_pulse", {pass_pulse, fail_pulse}, 0);
    act_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    chk("t7_ready_back", exp_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
